// File: rtl/pipe_out_buffer_if.sv
// Handshake/status bundle between user logic, host pipe endpoint and pipe_out_buffer.
// master: user/host side (drives wr_valid, wr_data, ep_read, clear_status).
// slave : buffer side (drives wr_ready, ep_datain, level, overflow, underflow, checksum).
interface pipe_out_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_valid;
  logic [15:0]           wr_data;
  logic                  wr_ready;
  logic                  ep_read;
  logic [15:0]           ep_datain;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  underflow;
  logic                  clear_status;
  logic [15:0]           checksum;

  modport master (
    output wr_valid, wr_data, ep_read, clear_status,
    input  wr_ready, ep_datain, level, overflow, underflow, checksum
  );

  modport slave (
    input  wr_valid, wr_data, ep_read, clear_status,
    output wr_ready, ep_datain, level, overflow, underflow, checksum
  );
endinterface

// File: rtl/pipe_out_buffer.sv
// First-word-fall-through buffer feeding a host pipe-out endpoint from user logic.
// Latency: a pushed word is on ep_datain the cycle after the push edge; pop advances head next cycle.
// Backpressure: wr_ready drops when full (pushes dropped, overflow set); reads while empty set underflow.
// Ports: ti_clk, reset (async active-high), bus (pipe_out_buffer_if.slave):
//   wr_valid/wr_data/wr_ready push side, ep_read/ep_datain host side,
//   level/overflow/underflow/checksum status, clear_status clears sticky flags and checksum.
// Option: define PIPE_OUT_BUFFER_CHECKSUM_EN to accumulate popped words into checksum.
module pipe_out_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              ti_clk,
  input  logic              reset,
  pipe_out_buffer_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   LVL_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full;
  logic                  empty;
  logic                  push_ok;
  logic                  pop_ok;
  logic [15:0]           head;

  // Status derived only from registered level, so wr_ready never depends on wr_valid/ep_read.
  assign full    = (level_q == FULL_LEVEL);
  assign empty   = (level_q == '0);
  assign push_ok = bus.wr_valid && !full;
  assign pop_ok  = bus.ep_read && !empty;
  assign head    = empty ? 16'h0000 : mem[rd_ptr];

  assign bus.wr_ready  = !full;
  assign bus.ep_datain = head;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  // Storage is not reset: level/pointers define what is valid.
  always_ff @(posedge ti_clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase

      // A new error event wins over a same-cycle clear.
      if (bus.wr_valid && full)       overflow_q <= 1'b1;
      else if (bus.clear_status)      overflow_q <= 1'b0;

      if (bus.ep_read && empty)       underflow_q <= 1'b1;
      else if (bus.clear_status)      underflow_q <= 1'b0;
    end
  end

`ifdef PIPE_OUT_BUFFER_CHECKSUM_EN
  logic [15:0] csum_q;

  // Clear restarts the sum; a pop on the clear edge becomes the first term.
  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      csum_q <= 16'h0000;
    end else if (bus.clear_status) begin
      csum_q <= pop_ok ? head : 16'h0000;
    end else if (pop_ok) begin
      csum_q <= csum_q + head;
    end
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_out_buffer.sv
module tb_pipe_out_buffer;
`ifdef PIPE_OUT_BUFFER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic ti_clk = 1'b0;
  logic reset  = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_out_buffer_if #(.DEPTH_LOG2(4)) bus ();

  pipe_out_buffer #(.DEPTH_LOG2(4)) dut (
    .ti_clk (ti_clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 ti_clk = ~ti_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle before sampling/driving.
  task automatic step();
    @(posedge ti_clk);
    #1;
  endtask

  initial begin
    bus.wr_valid     = 1'b1;   // ignored while reset is high
    bus.wr_data      = 16'h1234;
    bus.ep_read      = 1'b1;
    bus.clear_status = 1'b0;
    step();
    step();
    check_val("rst_level", bus.level, 0);
    check_val("rst_wr_ready", bus.wr_ready, 1);
    check_val("rst_datain", bus.ep_datain, 16'h0000);
    check_val("rst_overflow", bus.overflow, 0);
    check_val("rst_underflow", bus.underflow, 0);
    check_val("rst_checksum", bus.checksum, 16'h0000);
    bus.wr_valid = 1'b0;
    bus.ep_read  = 1'b0;
    reset        = 1'b0;
    step();

    // Fill 0x0001..0x0010
    for (int i = 1; i <= 16; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'(i);
      step();
      if (i == 1) check_val("fwft_first", bus.ep_datain, 16'h0001);
    end
    bus.wr_valid = 1'b0;
    check_val("fill_level", bus.level, 16);
    check_val("fill_wr_ready", bus.wr_ready, 0);

    // Push while full: dropped
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'hBEEF;
    step();
    bus.wr_valid = 1'b0;
    check_val("ovf_flag", bus.overflow, 1);
    check_val("ovf_level", bus.level, 16);
    check_val("ovf_head", bus.ep_datain, 16'h0001);
    bus.clear_status = 1'b1;
    step();
    bus.clear_status = 1'b0;
    check_val("ovf_clear", bus.overflow, 0);

    // Drain in order
    bus.ep_read = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check_val("drain_word", bus.ep_datain, 32'(i));
      step();
    end
    bus.ep_read = 1'b0;
    check_val("drain_level", bus.level, 0);
    check_val("drain_datain", bus.ep_datain, 16'h0000);
    check_val("drain_underflow", bus.underflow, 0);
    check_val("drain_checksum", bus.checksum, CSUM_EN ? 32'h0088 : 32'h0);

    // Empty with push and read together
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'hA5A5;
    bus.ep_read  = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.ep_read  = 1'b0;
    check_val("unf_flag", bus.underflow, 1);
    check_val("unf_level", bus.level, 1);
    check_val("unf_datain", bus.ep_datain, 16'hA5A5);
    bus.ep_read = 1'b1;
    step();
    // Read while empty in the same cycle as clear: set wins
    bus.clear_status = 1'b1;
    step();
    bus.ep_read = 1'b0;
    check_val("unf_set_prio", bus.underflow, 1);
    step();
    bus.clear_status = 1'b0;
    check_val("unf_clear", bus.underflow, 0);
    check_val("csum_cleared", bus.checksum, 16'h0000);

    // Checksum wraps modulo 2^16
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'hFFFF;
    step();
    bus.wr_data  = 16'h0003;
    step();
    bus.wr_valid = 1'b0;
    bus.ep_read  = 1'b1;
    step();
    step();
    bus.ep_read = 1'b0;
    check_val("csum_wrap", bus.checksum, CSUM_EN ? 32'h0002 : 32'h0);

    // Streaming 0..39 through the pointer wrap
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h0000;
    step();
    bus.ep_read = 1'b1;
    for (int i = 1; i <= 39; i++) begin
      bus.wr_data = 16'(i);
      check_val("stream_word", bus.ep_datain, 32'(i - 1));
      check_val("stream_level", bus.level, 1);
      step();
    end
    bus.wr_valid = 1'b0;
    check_val("stream_last", bus.ep_datain, 39);
    step();
    bus.ep_read = 1'b0;
    check_val("stream_empty", bus.level, 0);

    // Full with push and read: push rejected, pop done
    for (int i = 0; i < 16; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'(16'h0100 + i);
      step();
    end
    bus.wr_data = 16'hDEAD;
    bus.ep_read = 1'b1;
    check_val("fullrw_ready", bus.wr_ready, 0);
    step();
    bus.wr_valid = 1'b0;
    check_val("fullrw_level", bus.level, 15);
    check_val("fullrw_overflow", bus.overflow, 1);
    check_val("fullrw_head", bus.ep_datain, 16'h0101);
    for (int i = 0; i < 10; i++) step();
    bus.ep_read = 1'b0;
    check_val("mid_level", bus.level, 5);
    check_val("mid_head", bus.ep_datain, 16'h010B);

    // Reset between edges takes effect immediately
    #3;
    reset = 1'b1;
    #1;
    check_val("arst_level", bus.level, 0);
    check_val("arst_datain", bus.ep_datain, 16'h0000);
    check_val("arst_overflow", bus.overflow, 0);
    check_val("arst_wr_ready", bus.wr_ready, 1);
    #2;
    reset = 1'b0;
    step();
    check_val("post_rst_level", bus.level, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_out_buffer.md
PIPE_OUT_BUFFER -- requirements
Module: pipe_out_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving log2 of buffer depth in 16-bit words (depth 16); legal range 2..10.
REQ-002 SHALL have port ti_clk  input  1  the single clock, the same host-interface clock that drives the endpoints.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wr_valid  input  1  user logic offers a word.
REQ-005 SHALL have port wr_data  input  16  word offered by user logic.
REQ-006 SHALL have port wr_ready  output  1  buffer accepts a word this cycle.
REQ-007 SHALL have port ep_read  input  1  host pipe read strobe; one strobe consumes one word.
REQ-008 SHALL have port ep_datain  output  16  head word presented to the host pipe endpoint.
REQ-009 SHALL have port level  output  DEPTH_LOG2+1  stored word count, suitable for a status wire-out.
REQ-010 SHALL have port overflow  output  1  sticky flag: a push was attempted while full.
REQ-011 SHALL have port underflow  output  1  sticky flag: a read strobe arrived while empty.
REQ-012 SHALL have port clear_status  input  1  synchronous clear of the sticky flags and the checksum.
REQ-013 SHALL have port checksum  output  16  running sum of consumed words (see Configuration).

Function
REQ-014 SHALL accept a push on a rising ti_clk edge when wr_valid=1 and wr_ready=1.
REQ-015 SHALL drive wr_ready=1 exactly when level < 2^DEPTH_LOG2; it is registered-state driven, never combinationally dependent on wr_valid or ep_read.
REQ-016 SHALL be first-word-fall-through: ep_datain equals the oldest stored word in the same cycle level becomes non-zero, with zero added latency.
REQ-017 SHALL drive ep_datain=16'h0000 whenever level=0.
REQ-018 SHALL pop the head word on a rising edge when ep_read=1 and level>0; the next word appears on ep_datain the following cycle.
REQ-019 SHALL wrap read and write pointers modulo 2^DEPTH_LOG2 with no gap or duplicate across wrap-around.
REQ-020 SHALL, on simultaneous accepted push and valid pop, leave level unchanged and keep word order.
REQ-021 SHALL, when full with wr_valid=1 and ep_read=1, reject the push (wr_ready=0), perform the pop, set overflow and decrement level.
REQ-022 SHALL, when empty with wr_valid=1 and ep_read=1, accept the push, ignore the pop, set underflow, and end with level=1.
REQ-023 SHALL, for wr_valid=1 while full, drop the word, leave level unchanged and set overflow.
REQ-024 SHALL give a set event priority over clear_status in the same cycle, leaving the flag at 1.

Reset
REQ-025 SHALL, on reset assertion, immediately set level=0, both pointers=0, overflow=0, underflow=0 and checksum=0, with ep_datain=0 and wr_ready=1, independent of ti_clk.
REQ-026 SHALL discard buffered contents on reset mid-operation and ignore wr_valid and ep_read while reset=1.

Configuration
REQ-027 SHALL, with macro PIPE_OUT_BUFFER_CHECKSUM_EN defined, add each popped word into checksum modulo 2^16 on the pop edge; clear_status zeroes it, and a pop in the same cycle loads the popped word.
REQ-028 SHALL, without PIPE_OUT_BUFFER_CHECKSUM_EN, tie checksum to 16'h0000 and instantiate no adder logic.

Verification
REQ-029 SHALL cover fill/drain: push 16'h0001..16'h0010 with DEPTH_LOG2=4 -> level=16, wr_ready=0; 16 ep_read strobes return 0x0001..0x0010 in order, then level=0, ep_datain=0.
REQ-030 SHALL cover overflow: after the fill above, one more push of 16'hBEEF -> word dropped, overflow=1, level=16; clear_status pulse -> overflow=0.
REQ-031 SHALL cover underflow with a simultaneous push: level=0, wr_valid=1, wr_data=16'hA5A5, ep_read=1 -> underflow=1, level=1, ep_datain=0xA5A5.
REQ-032 SHALL cover wrap-around streaming: 40 words 0..39 with simultaneous push and pop every cycle after the first push -> level holds at 1 and the output sequence is 0..39 unbroken.
REQ-033 SHALL cover checksum with the macro defined: pop 16'hFFFF then 16'h0003 -> checksum=16'h0002; without the macro, checksum stays 0.
REQ-034 SHALL cover reset mid-stream: assert reset between edges with level=5 -> level=0, ep_datain=0 and flags cleared immediately, before the next ti_clk edge.
